// File: rtl/pc_unit.sv
// pc_unit -- program counter for the 6502 core, held as low/high halves.
//
// Supports increment, parallel load and signed relative branch. A relative
// branch only adds the displacement into the low half. When that crosses a
// page, the high half is corrected on a second, FIXUP cycle, as the real
// 6502 does, and busy/page_cross tell the control unit that this cycle is in
// progress.
//
// Build option: define PC_PAGE_FIXUP_EN for the two-cycle page-cross
// behaviour. Without it, no FIXUP state is built. A branch then adds the
// sign-extended offset across the whole PC in one cycle, and busy is tied
// low.
//
// Ports:
//   clk        in   1  clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   inc_enable in   1  PC <= PC + 1
//   load       in   1  PC <= {PCH_in, PCL_in}
//   branch     in   1  PC <= PC + signed offset (relative branch taken)
//   PCL_in     in   H  low half load value
//   PCH_in     in   H  high half load value
//   offset     in   H  two's-complement branch displacement
//   PCL_out    out  H  registered low half
//   PCH_out    out  H  registered high half
//   busy       out  1  page fix-up in progress; requests are dropped
//   page_cross out  1  one-cycle pulse after a branch changed the page
//   Request priority: load > branch > inc_enable. H = ADDR_W/2.
module pc_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'hFFFC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_enable,
  input  logic                  load,
  input  logic                  branch,
  input  logic [ADDR_W/2-1:0]   PCL_in,
  input  logic [ADDR_W/2-1:0]   PCH_in,
  input  logic [ADDR_W/2-1:0]   offset,
  output logic [ADDR_W/2-1:0]   PCL_out,
  output logic [ADDR_W/2-1:0]   PCH_out,
  output logic                  busy,
  output logic                  page_cross
);

  localparam int                H     = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] ONE_W = ADDR_W'(1);

  logic [H-1:0]      pcl_q, pcl_d;
  logic [H-1:0]      pch_q, pch_d;
  logic              cross_q, cross_d;
  logic [ADDR_W-1:0] pc_inc;

  // Increment carries into the high half in the same cycle.
  assign pc_inc = {pch_q, pcl_q} + ONE_W;

`ifdef PC_PAGE_FIXUP_EN
  localparam logic [H-1:0] ONE_H = H'(1);

  typedef enum logic {
    RUN   = 1'b0,
    FIXUP = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic         up_q, up_d;
  logic [H:0]   sum;

  // Low-half add only. The carry out and the offset sign together say
  // whether the page changed.
  assign sum = {1'b0, pcl_q} + {1'b0, offset};

  always_comb begin
    pcl_d   = pcl_q;
    pch_d   = pch_q;
    cross_d = 1'b0;
    state_d = state_q;
    up_d    = up_q;
    case (state_q)
      RUN: begin
        if (load) begin
          pcl_d = PCL_in;
          pch_d = PCH_in;
        end else if (branch) begin
          pcl_d = sum[H-1:0];
          // carry=1 with a positive offset is a forward cross, and
          // carry=0 with a negative offset is a backward cross. Either way
          // the carry differs from the sign, and the carry gives the
          // direction.
          if (sum[H] != offset[H-1]) begin
            state_d = FIXUP;
            up_d    = sum[H];
            cross_d = 1'b1;
          end
        end else if (inc_enable) begin
          {pch_d, pcl_d} = pc_inc;
        end
      end
      FIXUP: begin
        // Requests are ignored here and are not queued.
        pch_d   = up_q ? (pch_q + ONE_H) : (pch_q - ONE_H);
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
    end
  end

  assign busy = (state_q == FIXUP);
`else
  logic [ADDR_W-1:0] pc_br;

  assign pc_br = {pch_q, pcl_q} + {{H{offset[H-1]}}, offset};

  always_comb begin
    pcl_d   = pcl_q;
    pch_d   = pch_q;
    cross_d = 1'b0;
    if (load) begin
      pcl_d = PCL_in;
      pch_d = PCH_in;
    end else if (branch) begin
      {pch_d, pcl_d} = pc_br;
      cross_d        = (pc_br[ADDR_W-1:H] != pch_q);
    end else if (inc_enable) begin
      {pch_d, pcl_d} = pc_inc;
    end
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcl_q   <= RESET_PC[H-1:0];
      pch_q   <= RESET_PC[ADDR_W-1:H];
      cross_q <= 1'b0;
    end else begin
      pcl_q   <= pcl_d;
      pch_q   <= pch_d;
      cross_q <= cross_d;
    end
  end

  assign PCL_out    = pcl_q;
  assign PCH_out    = pch_q;
  assign page_cross = cross_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inc_enable = 1'b0;
  logic       load = 1'b0;
  logic       branch = 1'b0;
  logic [7:0] PCL_in = 8'h00;
  logic [7:0] PCH_in = 8'h00;
  logic [7:0] offset = 8'h00;
  logic [7:0] PCL_out;
  logic [7:0] PCH_out;
  logic       busy;
  logic       page_cross;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  pc_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .inc_enable (inc_enable),
    .load       (load),
    .branch     (branch),
    .PCL_in     (PCL_in),
    .PCH_in     (PCH_in),
    .offset     (offset),
    .PCL_out    (PCL_out),
    .PCH_out    (PCH_out),
    .busy       (busy),
    .page_cross (page_cross)
  );

  always #5 clk = ~clk;

  // Reference model: the PC as one 16-bit number. A branch target is the
  // full-width sum with the sign-extended offset. With the fix-up option
  // enabled, a target on another page is reached in two steps: the low byte
  // first, then the high byte on the following cycle.
  logic [15:0] m_pc = 16'hFFFC;
  bit          m_fix = 1'b0;
  logic [7:0]  m_tgt = 8'h00;
  bit          m_busy = 1'b0;
  bit          m_cross = 1'b0;

  function automatic logic [15:0] br_target(input logic [15:0] pc, input logic [7:0] off);
    return pc + {{8{off[7]}}, off};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= 16'hFFFC;
      m_fix   <= 1'b0;
      m_busy  <= 1'b0;
      m_cross <= 1'b0;
    end else begin
      m_busy  <= 1'b0;
      m_cross <= 1'b0;
      m_fix   <= 1'b0;
      if (m_fix) begin
        m_pc[15:8] <= m_tgt;
      end else if (load) begin
        m_pc <= {PCH_in, PCL_in};
      end else if (branch) begin
`ifdef PC_PAGE_FIXUP_EN
        if (br_target(m_pc, offset) >> 8 != m_pc >> 8) begin
          m_pc[7:0] <= br_target(m_pc, offset) & 16'h00FF;
          m_tgt     <= 8'(br_target(m_pc, offset) >> 8);
          m_fix     <= 1'b1;
          m_busy    <= 1'b1;
          m_cross   <= 1'b1;
        end else begin
          m_pc <= br_target(m_pc, offset);
        end
`else
        m_pc    <= br_target(m_pc, offset);
        m_cross <= (br_target(m_pc, offset) >> 8 != m_pc >> 8);
`endif
      end else if (inc_enable) begin
        m_pc <= m_pc + 16'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started && reset) begin
      chk("model_pc", {PCH_out, PCL_out}, m_pc);
      chk("model_flags", {14'b0, busy, page_cross}, {14'b0, m_busy, m_cross});
    end
  end

  task automatic chk_pc(input string nm, input logic [15:0] exp);
    chk(nm, {PCH_out, PCL_out}, exp);
  endtask

  task automatic chk_fl(input string nm, input logic b, input logic c);
    chk(nm, {14'b0, busy, page_cross}, {14'b0, b, c});
  endtask

  task automatic cyc(input logic ld, input logic br, input logic inc,
                     input logic [7:0] pl, input logic [7:0] ph, input logic [7:0] off);
    load       = ld;
    branch     = br;
    inc_enable = inc;
    PCL_in     = pl;
    PCH_in     = ph;
    offset     = off;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b1;
    started = 1'b1;

    // Reset state with idle inputs
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk_pc("reset_pc", 16'hFFFC);
    chk_fl("reset_flags", 1'b0, 1'b0);

    // Load and increment run
    cyc(1, 0, 0, 8'h3F, 8'hFE, 8'h00);
    chk_pc("load_fe3f", 16'hFE3F);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk_pc("inc_fe47", 16'hFE47);

    // Wrap from all-ones
    cyc(1, 0, 0, 8'hFF, 8'hFF, 8'h00);
    cyc(0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk_pc("inc_wrap", 16'h0000);

    // Branch within a page
    cyc(1, 0, 0, 8'h20, 8'h10, 8'h00);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h10);
    chk_pc("br_same_page", 16'h1030);
    chk_fl("br_same_flags", 1'b0, 1'b0);

    // Forward page cross, inc held through the fix-up cycle
    cyc(1, 0, 0, 8'hF0, 8'h10, 8'h00);
    cyc(0, 1, 1, 8'h00, 8'h00, 8'h20);
`ifdef PC_PAGE_FIXUP_EN
    chk_pc("fwd_edge1", 16'h1010);
    chk_fl("fwd_edge1_flags", 1'b1, 1'b1);
    cyc(0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk_pc("fwd_edge2", 16'h1110);
    chk_fl("fwd_edge2_flags", 1'b0, 1'b0);
    cyc(0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk_pc("fwd_inc_after", 16'h1111);
`else
    chk_pc("fwd_oneedge", 16'h1110);
    chk_fl("fwd_oneedge_flags", 1'b0, 1'b1);
    cyc(0, 0, 1, 8'h00, 8'h00, 8'h00);
    chk_pc("fwd_inc_after", 16'h1111);
    chk_fl("fwd_inc_flags", 1'b0, 1'b0);
`endif

    // Backward page cross
    cyc(1, 0, 0, 8'h05, 8'h10, 8'h00);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'hF0);
`ifdef PC_PAGE_FIXUP_EN
    chk_pc("bwd_edge1", 16'h10F5);
    chk_fl("bwd_edge1_flags", 1'b1, 1'b1);
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk_pc("bwd_edge2", 16'h0FF5);
`else
    chk_pc("bwd_oneedge", 16'h0FF5);
    chk_fl("bwd_oneedge_flags", 1'b0, 1'b1);
`endif

    // Simultaneous load + branch + inc: load wins, no cross
    cyc(1, 0, 0, 8'h34, 8'h12, 8'h00);
    cyc(1, 1, 1, 8'h56, 8'h78, 8'h80);
    chk_pc("all_three", 16'h7856);
    chk_fl("all_three_flags", 1'b0, 1'b0);

    // Asynchronous reset in the cycle after a crossing branch
    cyc(1, 0, 0, 8'hF0, 8'hFF, 8'h00);
    cyc(0, 1, 0, 8'h00, 8'h00, 8'h20);
    load = 1'b0; branch = 1'b0; inc_enable = 1'b0;
    reset = 1'b0;
    #1;
    chk_pc("reset_mid_pc", 16'hFFFC);
    chk_fl("reset_mid_flags", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    chk_pc("reset_mid_discard", 16'hFFFC);

    // Randomised traffic, checked every cycle against the model
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          8'($urandom), 8'($urandom), 8'($urandom));
    end
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 8'h00, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
